// File: rtl/vp_pixel_serializer_if.sv
// Bundle between the bitmap merge stage, the pixel serializer and the palette/DAC stage.
// The master drives the word, the strobes and the pixel tick; the slave (serializer) returns pixel and status.
interface vp_pixel_serializer_if;
   logic [3:0]  foreground;
   logic [3:0]  background;
   logic [15:0] bitmap;
   logic        enable;
   logic        load;
   logic        pixel_en;
   logic        flush;
   logic [3:0]  pixel_color;
   logic        pixel_visible;
   logic        ready;
   logic        underrun;
   logic        overflow;

   modport master (
      output foreground, background, bitmap, enable, load, pixel_en, flush,
      input  pixel_color, pixel_visible, ready, underrun, overflow
   );

   modport slave (
      input  foreground, background, bitmap, enable, load, pixel_en, flush,
      output pixel_color, pixel_visible, ready, underrun, overflow
   );
endinterface

// File: rtl/vp_pixel_serializer.sv
// Double-buffered 16-pixel word to 4-bit colour serializer, MSB first, one pixel per pixel_en tick.
// A word loaded at edge N shows from the next tick after N; ready drops while the pending slot is full.
module vp_pixel_serializer #(
   parameter logic [3:0] BLANK_COLOR = 4'd0
) (
   input logic clk,
   input logic reset,
   vp_pixel_serializer_if.slave bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]  state;
   logic [3:0]  pend_fg;
   logic [3:0]  pend_bg;
   logic [15:0] pend_bitmap;
   logic        pend_en;
   logic        pend_full;
   logic [3:0]  act_fg;
   logic [3:0]  act_bg;
   logic [14:0] act_shift;
   logic        act_en;
   logic [3:0]  remaining;
   logic [3:0]  color_q;
   logic        visible_q;
   logic        underrun_q;
   logic        overflow_q;

   logic at_end;
   logic transfer;

   // The active word is exhausted once its last pixel is on the output.
   assign at_end   = (state == IDLE) || (remaining == 4'd0);
   assign transfer = bus.pixel_en && at_end && pend_full;

   assign bus.pixel_color   = color_q;
   assign bus.pixel_visible = visible_q;
   assign bus.ready         = ~pend_full;
   assign bus.underrun      = underrun_q;
   assign bus.overflow      = overflow_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pend_fg     <= 4'd0;
         pend_bg     <= 4'd0;
         pend_bitmap <= 16'd0;
         pend_en     <= 1'b0;
         pend_full   <= 1'b0;
         act_fg      <= 4'd0;
         act_bg      <= 4'd0;
         act_shift   <= 15'd0;
         act_en      <= 1'b0;
         remaining   <= 4'd0;
         color_q     <= BLANK_COLOR;
         visible_q   <= 1'b0;
         underrun_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (bus.flush) begin
         pend_full  <= 1'b0;
         state      <= IDLE;
         remaining  <= 4'd0;
         color_q    <= BLANK_COLOR;
         visible_q  <= 1'b0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;

         // A load on the transfer edge refills the slot the transfer just emptied.
         if (bus.load) begin
            pend_fg     <= bus.foreground;
            pend_bg     <= bus.background;
            pend_bitmap <= bus.bitmap;
            pend_en     <= bus.enable;
            pend_full   <= 1'b1;
            overflow_q  <= pend_full && !transfer;
         end else if (transfer) begin
            pend_full <= 1'b0;
         end

         if (bus.pixel_en) begin
            if (!at_end) begin
               color_q   <= act_en ? (act_shift[14] ? act_fg : act_bg) : BLANK_COLOR;
               visible_q <= act_en;
               act_shift <= {act_shift[13:0], 1'b0};
               remaining <= remaining - 4'd1;
            end else if (pend_full) begin
               color_q   <= pend_en ? (pend_bitmap[15] ? pend_fg : pend_bg) : BLANK_COLOR;
               visible_q <= pend_en;
               act_fg    <= pend_fg;
               act_bg    <= pend_bg;
               act_en    <= pend_en;
               act_shift <= pend_bitmap[14:0];
               remaining <= 4'd15;
               state     <= RUN;
            end else begin
               // Starving before the first word is not an underrun, only running dry mid-stream.
               color_q    <= BLANK_COLOR;
               visible_q  <= 1'b0;
               underrun_q <= (state == RUN);
               state      <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_vp_pixel_serializer.sv
// Scoreboard bench for vp_pixel_serializer: each loaded word queues its 16 expected pixels, each tick pops one.
module tb_vp_pixel_serializer;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   logic [4:0] exp_q[$];
   logic [4:0] last_exp;

   vp_pixel_serializer_if sif ();

   vp_pixel_serializer #(.BLANK_COLOR(4'd0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_word(input logic [3:0] fg, input logic [3:0] bg,
                           input logic [15:0] bm, input logic en);
      sif.foreground = fg;
      sif.background = bg;
      sif.bitmap     = bm;
      sif.enable     = en;
   endtask

   // Queue the 16 pixels of the word currently on the inputs, leftmost first.
   task automatic push_word();
      for (int i = 15; i >= 0; i--) begin
         if (sif.enable)
            exp_q.push_back({1'b1, sif.bitmap[i] ? sif.foreground : sif.background});
         else
            exp_q.push_back(5'b0_0000);
      end
   endtask

   task automatic step(input logic pe, input logic ld, input logic fl);
      logic [4:0] e;
      sif.pixel_en = pe;
      sif.load     = ld;
      sif.flush    = fl;
      @(posedge clk);
      #1;
      sif.pixel_en = 1'b0;
      sif.load     = 1'b0;
      sif.flush    = 1'b0;
      if (pe && !fl) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("underrun_mid", {15'd0, sif.underrun}, 16'd0);
         end else begin
            e = 5'b0_0000;
         end
         last_exp = e;
         chk("pixel", {11'd0, sif.pixel_visible, sif.pixel_color}, {11'd0, e});
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      last_exp    = 5'd0;
      sif.pixel_en = 1'b0;
      sif.load     = 1'b0;
      sif.flush    = 1'b0;
      set_word(4'd0, 4'd0, 16'd0, 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_color", {12'd0, sif.pixel_color}, 16'd0);
      chk("rst_visible", {15'd0, sif.pixel_visible}, 16'd0);
      chk("rst_ready", {15'd0, sif.ready}, 16'd1);
      chk("rst_underrun", {15'd0, sif.underrun}, 16'd0);
      chk("rst_overflow", {15'd0, sif.overflow}, 16'd0);
      reset = 1'b0;
      step(0, 0, 0);

      // Single word A/3 with end pixels set, then run dry.
      set_word(4'hA, 4'h3, 16'h8001, 1'b1);
      push_word();
      step(0, 1, 0);
      chk("t1_ready_after_load", {15'd0, sif.ready}, 16'd0);
      for (int i = 0; i < 16; i++) step(1, 0, 0);
      step(1, 0, 0);
      chk("t1_underrun", {15'd0, sif.underrun}, 16'd1);
      step(0, 0, 0);
      chk("t1_underrun_1cyc", {15'd0, sif.underrun}, 16'd0);

      // Back-to-back words, second loaded mid-word.
      set_word(4'h5, 4'h0, 16'hFFFF, 1'b1);
      push_word();
      step(0, 1, 0);
      step(1, 0, 0);
      chk("t2_ready_after_xfer", {15'd0, sif.ready}, 16'd1);
      for (int i = 1; i < 5; i++) step(1, 0, 0);
      set_word(4'h0, 4'h7, 16'h0000, 1'b1);
      push_word();
      step(1, 1, 0);
      chk("t2_ready_load2", {15'd0, sif.ready}, 16'd0);
      chk("t2_no_overflow", {15'd0, sif.overflow}, 16'd0);
      while (exp_q.size() > 16) step(1, 0, 0);
      step(1, 0, 0);
      chk("t2_ready_xfer2", {15'd0, sif.ready}, 16'd1);
      while (exp_q.size() > 0) step(1, 0, 0);
      step(1, 0, 0);
      chk("t2_underrun_end", {15'd0, sif.underrun}, 16'd1);

      // Disabled word still takes 16 ticks.
      set_word(4'h5, 4'h2, 16'hFFFF, 1'b0);
      push_word();
      step(0, 1, 0);
      for (int i = 0; i < 16; i++) step(1, 0, 0);
      step(1, 0, 0);
      chk("t3_underrun_end", {15'd0, sif.underrun}, 16'd1);

      // Three loads without ticks: only the third survives.
      set_word(4'h1, 4'h2, 16'hAAAA, 1'b1);
      step(0, 1, 0);
      chk("t4_ovf_first", {15'd0, sif.overflow}, 16'd0);
      set_word(4'h3, 4'h4, 16'h5555, 1'b1);
      step(0, 1, 0);
      chk("t4_ovf_second", {15'd0, sif.overflow}, 16'd1);
      step(0, 0, 0);
      chk("t4_ovf_pulse", {15'd0, sif.overflow}, 16'd0);
      set_word(4'hB, 4'h6, 16'h3C0F, 1'b1);
      push_word();
      step(0, 1, 0);
      chk("t4_ovf_third", {15'd0, sif.overflow}, 16'd1);
      for (int i = 0; i < 16; i++) step(1, 0, 0);
      step(1, 0, 0);
      chk("t4_underrun_end", {15'd0, sif.underrun}, 16'd1);

      // Tick every third cycle: each pixel holds.
      set_word(4'hC, 4'h1, 16'hA5C3, 1'b1);
      push_word();
      step(0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         step(1, 0, 0);
         for (int j = 0; j < 2; j++) begin
            step(0, 0, 0);
            chk("t5_hold", {11'd0, sif.pixel_visible, sif.pixel_color}, {11'd0, last_exp});
         end
      end
      step(1, 0, 0);
      chk("t5_underrun_end", {15'd0, sif.underrun}, 16'd1);

      // Flush after 5 pixels with a simultaneous load.
      set_word(4'h9, 4'h6, 16'hF0F0, 1'b1);
      push_word();
      step(0, 1, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      set_word(4'hD, 4'h8, 16'h1234, 1'b1);
      step(1, 1, 1);
      exp_q.delete();
      chk("t6_flush_color", {11'd0, sif.pixel_visible, sif.pixel_color}, 16'd0);
      chk("t6_flush_ready", {15'd0, sif.ready}, 16'd1);
      chk("t6_flush_underrun", {15'd0, sif.underrun}, 16'd0);
      chk("t6_flush_overflow", {15'd0, sif.overflow}, 16'd0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0);
         chk("t6_post_underrun", {15'd0, sif.underrun}, 16'd0);
      end

      // Asynchronous reset mid-word with a pending word queued.
      set_word(4'hE, 4'h4, 16'hFFFF, 1'b1);
      push_word();
      step(0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0);
      set_word(4'h2, 4'h2, 16'h0F0F, 1'b1);
      push_word();
      step(1, 1, 0);
      chk("t7_ready_pre", {15'd0, sif.ready}, 16'd0);
      #1;
      reset = 1'b1;
      #1;
      chk("t7_arst_color", {11'd0, sif.pixel_visible, sif.pixel_color}, 16'd0);
      chk("t7_arst_ready", {15'd0, sif.ready}, 16'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1, 0, 0);
      chk("t7_post_underrun", {15'd0, sif.underrun}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vp_pixel_serializer.md
Name: vp_pixel_serializer

Overview:
- Downstream of the bitmap merge stage: takes one merged 16-pixel word per load (foreground, background, bitmap, enable) and emits one 4-bit colour index per pixel-enable tick, MSB first.
- Double-buffered (pending + active), so the upstream stage can deliver the next word while the current one is being shifted out.
- Output feeds the palette/DAC stage.

Parameters:
- BLANK_COLOR, 4'd0, colour index driven when there is nothing to display (disabled word, idle, underrun).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- foreground, input, 4, colour index for bitmap bits = 1.
- background, input, 4, colour index for bitmap bits = 0.
- bitmap, input, 16, pixel word; bit 15 is the leftmost pixel.
- enable, input, 1, word contains displayable data.
- load, input, 1, strobe: capture inputs into the pending buffer.
- pixel_en, input, 1, pixel tick: advance one pixel.
- flush, input, 1, synchronous clear (start of line/frame).
- pixel_color, output, 4, registered colour index of the current pixel.
- pixel_visible, output, 1, registered; 1 when pixel_color comes from an enabled word.
- ready, output, 1, pending buffer empty (equals ~pending_full).
- underrun, output, 1, one-cycle pulse: a pixel tick found no data.
- overflow, output, 1, one-cycle pulse: a load overwrote an unconsumed pending word.

Behaviour:
- State
  - Pending register {fg, bg, bitmap, en, pending_full}.
  - Active register {fg, bg, shift[14:0], en}.
  - remaining counter, 4 bits: pixels left in active after the current output.
  - FSM with states IDLE and RUN.
- Reset values: pending_full=0, state=IDLE, remaining=0, pixel_color=BLANK_COLOR, pixel_visible=0, underrun=0, overflow=0, ready=1.
- Pixel colour rule: bit=1 gives fg, bit=0 gives bg.
  - If the word's en=0: pixel_color=BLANK_COLOR and pixel_visible=0 for all 16 pixels. The word still occupies 16 ticks.
- Load: on a clk edge with load=1, pending takes the inputs and pending_full<=1.
- Pixel tick (pixel_en=1), evaluated on pending contents from before the edge:
  - RUN and remaining>0: output takes shift[14] (coloured), shift<<=1, remaining--.
  - (RUN and remaining=0) or IDLE, with pending_full=1 (transfer):
    - output takes pending bitmap[15] coloured with pending fg/bg/en.
    - shift<=bitmap[14:0], remaining<=15, state<=RUN.
    - pending_full<=0, unless load=1 in the same cycle, which refills pending and keeps it at 1.
  - RUN and remaining=0, with pending_full=0: pixel_color<=BLANK_COLOR, pixel_visible<=0, state<=IDLE, underrun pulses 1 cycle.
  - IDLE, with pending_full=0: output blank, no underrun (no underrun is reported before the first word).
- No pixel_en: outputs hold, counter and shift hold.
- Latency: a word loaded at edge N is displayable from the first pixel_en edge after N. There is no same-edge bypass from load to output.
- Overflow: load=1 while pending_full=1 and no transfer on that edge → pending overwritten, overflow pulses 1 cycle. If a transfer happens on the same edge, no overflow.
- flush=1 has priority over load and pixel_en:
  - pending_full<=0, state<=IDLE, remaining<=0.
  - outputs blank, no underrun/overflow pulse.
  - load on the same cycle is discarded.
- Asynchronous reset mid-word returns all state to the reset values immediately.
- Throughput: one word per 16 ticks. With pixel_en=1 every cycle, back-to-back words give gapless output if each load lands at least 1 cycle before the transfer edge.

Test Plan:
- Reset, then load {fg=4'hA, bg=4'h3, bitmap=16'h8001, en=1}, then 16 consecutive pixel_en → pixel_color sequence A,3×14,A with pixel_visible=1; then the 17th tick → BLANK_COLOR, visible=0, underrun=1 for 1 cycle.
- Two words 16'hFFFF (fg=5) and 16'h0000 (bg=7); second load during the first word, pixel_en every cycle → 16×5 then 16×7 with no gap; ready deasserts after each load and reasserts after transfer; no underrun.
- Load with en=0 and bitmap=16'hFFFF → 16 ticks of BLANK_COLOR with visible=0; no underrun during those 16 ticks.
- Three loads without pixel_en → overflow pulses on the 2nd and 3rd loads; the output then shows only the 3rd word.
- pixel_en asserted every 3rd cycle → each pixel holds for 3 cycles and the order is preserved.
- Mid-word flush (after 5 pixels) with a simultaneous load → blank outputs, pending empty, ready=1, no underrun on later ticks; assert async reset mid-word → outputs go to reset values without a clock edge.
